// File: rtl/mbscore_vec_int_ctrl.sv
// Vectored, nesting interrupt controller for the MBScore CPU: latches edge/level
// requests, applies mask and fixed priority, and issues a one-cycle PC redirect.
module mbscore_vec_int_ctrl #(
  parameter int                    NUM_IRQ         = 16,
  parameter int                    ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] VEC_BASE        = ADDR_WIDTH'('h80),
  parameter int                    VEC_STRIDE_LOG2 = 2,
  parameter logic [NUM_IRQ-1:0]    TRIG_EDGE       = {NUM_IRQ{1'b1}},
  parameter logic [NUM_IRQ-1:0]    RESET_MASK      = {NUM_IRQ{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_IRQ-1:0]         irq_in,
  input  logic                       int_en_n,
  input  logic                       stop,
  input  logic                       eoi,
  input  logic                       mask_we,
  input  logic [NUM_IRQ-1:0]         mask_in,
  output logic [NUM_IRQ-1:0]         mask_out,
  output logic [NUM_IRQ-1:0]         pending_out,
  output logic [NUM_IRQ-1:0]         in_service,
  output logic                       int_jump,
  output logic                       setINTR,
  output logic [ADDR_WIDTH-1:0]      int_addr,
  output logic [$clog2(NUM_IRQ)-1:0] int_id
);

  localparam int IDW = $clog2(NUM_IRQ);
  localparam int THW = IDW + 1;

  typedef enum logic {IDLE, ARMED} state_e;

  state_e                state_q, state_d;
  logic [NUM_IRQ-1:0]    irq_q;
  logic [NUM_IRQ-1:0]    pending_q, pending_d;
  logic [NUM_IRQ-1:0]    in_service_q, in_service_d;
  logic [NUM_IRQ-1:0]    mask_q;
  logic                  jump_q;
  logic [IDW-1:0]        id_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic [NUM_IRQ-1:0]    eligible;
  logic [NUM_IRQ-1:0]    winnerVec;
  logic [NUM_IRQ-1:0]    eoiVec;
  logic [IDW-1:0]        winner;
  logic [THW-1:0]        threshold;
  logic                  hasReq;
  logic                  qualify;
  logic                  dispatch;

  // Lowest set index wins for both the request and the in-service threshold.
  always_comb begin
    eligible  = pending_q & ~mask_q;
    winner    = '0;
    hasReq    = 1'b0;
    threshold = THW'(NUM_IRQ);
    eoiVec    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = IDW'(i);
        hasReq = 1'b1;
      end
      if (in_service_q[i]) begin
        threshold = THW'(i);
        eoiVec    = NUM_IRQ'(1) << i;
      end
    end
    winnerVec = NUM_IRQ'(1) << winner;
    qualify   = hasReq && ({1'b0, winner} < threshold) && !int_en_n;
  end

  always_comb begin
    state_d  = state_q;
    dispatch = 1'b0;
    case (state_q)
      IDLE: begin
        if (qualify) state_d = ARMED;
      end
      ARMED: begin
        if (!qualify) begin
          state_d = IDLE;
        end else if (stop) begin
          dispatch = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Edge channels: set on rising edge, cleared by dispatch, set wins a tie.
  always_comb begin
    pending_d = (TRIG_EDGE & ((pending_q & ~(dispatch ? winnerVec : '0)) | (irq_in & ~irq_q)))
              | (~TRIG_EDGE & irq_in);
    in_service_d = (in_service_q & ~(eoi ? eoiVec : '0)) | (dispatch ? winnerVec : '0);
    addr_d = VEC_BASE + (ADDR_WIDTH'(winner) << VEC_STRIDE_LOG2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      irq_q        <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      mask_q       <= RESET_MASK;
      jump_q       <= 1'b0;
      id_q         <= '0;
      addr_q       <= VEC_BASE;
    end else begin
      state_q      <= state_d;
      irq_q        <= irq_in;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      jump_q       <= dispatch;
      if (mask_we) mask_q <= mask_in;
      if (dispatch) begin
        id_q   <= winner;
        addr_q <= addr_d;
      end
    end
  end

  assign mask_out    = mask_q;
  assign pending_out = pending_q;
  assign in_service  = in_service_q;
  assign int_jump    = jump_q;
  assign setINTR     = jump_q;
  assign int_addr    = addr_q;
  assign int_id      = id_q;

endmodule

// File: doc/mbscore_vec_int_ctrl.md
# mbscore_vec_int_ctrl

Parametrised, vectored, nesting interrupt controller for the MBScore CPU, successor to the fixed 16-bit-vector interrupt controller. It latches up to NUM_IRQ edge- or level-triggered requests, applies per-channel masks and fixed priority with in-service nesting, and at an instruction boundary (`stop`) issues a one-cycle PC redirect to a per-channel vector address. It sits beside the IR/PC block and register file in the CPU top.

## Interface
- NUM_IRQ, 16: number of request channels (2..32); channel 0 has the highest priority.
- ADDR_WIDTH, 32: vector address width.
- VEC_BASE, 32'h0000_0080: vector table base address.
- VEC_STRIDE_LOG2, 2: log2 byte spacing of vector entries.
- TRIG_EDGE, {NUM_IRQ{1'b1}}: per-channel trigger mode, 1 = rising edge, 0 = level-high.
- RESET_MASK, {NUM_IRQ{1'b0}}: mask value loaded at reset (1 = masked).
- IDW: localparam, $clog2(NUM_IRQ).

Ports:
- clk  in  1  CPU clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- irq_in  in  NUM_IRQ  raw request lines, synchronous to clk.
- int_en_n  in  1  global interrupt enable from SPR; 0 = enabled.
- stop  in  1  CPU at an instruction boundary; dispatch is allowed only when high.
- eoi  in  1  one-cycle end-of-interrupt pulse from the return instruction.
- mask_we  in  1  mask register write strobe.
- mask_in  in  NUM_IRQ  new mask value.
- mask_out  out  NUM_IRQ  current mask.
- pending_out  out  NUM_IRQ  current pending vector.
- in_service  out  NUM_IRQ  in-service (nesting) bits.
- int_jump  out  1  one-cycle registered pulse: load PC with int_addr.
- setINTR  out  1  one-cycle registered pulse, coincident with int_jump: set the INTR disable bit in the register file.
- int_addr  out  ADDR_WIDTH  vector address of the dispatched channel.
- int_id  out  IDW  dispatched channel index.

## Operation
- irq_q is a registered copy of irq_in. Edge channel k: pending[k] is set at the edge where irq_in[k] & ~irq_q[k]. It is cleared only when channel k is dispatched; if a set and a clear coincide, the set wins. Level channel k: pending[k] <= irq_in[k] every cycle, and dispatch does not clear it.
- eligible = pending & ~mask. winner = lowest index in eligible.
- Threshold = index of the highest-priority set in_service bit, or NUM_IRQ if none. A request qualifies when eligible ≠ 0, winner < threshold, and int_en_n == 0.
- State machine:
  - IDLE: if a request qualifies, go to ARMED.
  - ARMED:
    - If a request qualifies and stop == 1, dispatch and go to IDLE.
    - If no request qualifies (masked, withdrawn, or int_en_n == 1), go to IDLE with no output.
    - The winner is re-evaluated every cycle, so a higher-priority arrival overrides the earlier one.
- Dispatch, registered:
  - int_jump = 1 and setINTR = 1 for exactly one cycle.
  - int_id = winner.
  - int_addr = (VEC_BASE + (winner << VEC_STRIDE_LOG2)) mod 2^ADDR_WIDTH.
  - in_service[winner] is set, and an edge pending bit is cleared.
  - int_addr and int_id hold until the next dispatch.
- eoi clears the highest-priority set in_service bit; it has no effect when none is set. When eoi and a dispatch fall in the same cycle, the threshold uses the pre-eoi in_service value and both updates apply.
- mask_we loads mask_in at the edge. A mask change takes effect on qualification in the following cycle.
- Level channel still high after eoi: it is re-taken (software must clear the source first).

## Timing
- Reset values:
  - int_jump = 0, setINTR = 0, int_id = 0, int_addr = VEC_BASE.
  - pending = 0, in_service = 0, irq_q = 0, mask = RESET_MASK, state = IDLE.
- Reset mid-operation: everything above is restored; edges occurring during reset are lost. A line held high through reset deassertion registers as a new edge on the first sample after reset.
- Best-case latency: irq_in rises before edge E0; pending is set at E0; ARMED at E1; with stop = 1 in cycle E1..E2, int_jump is high during E2..E3. That is 3 edges from the first sampling edge.
- stop low holds ARMED indefinitely; no pulse is ever longer than one cycle.
- The minimum spacing between consecutive int_jump pulses is 2 cycles (IDLE→ARMED→dispatch).

## Test plan
- Edge ch 5 alone (all unmasked, int_en_n = 0, stop = 1): irq_in[5] 0→1 sampled at E0 -> int_jump and setINTR high for one cycle after E2, int_id = 5, int_addr = 0x94, pending[5] = 0, in_service = 0x0020.
- Simultaneous edges on ch 3 and 9 while stop = 0 for 10 cycles, then stop = 1 -> dispatch ch 3 (addr 0x8C) only. After eoi, ch 9 dispatches 2 cycles later at addr 0xA4.
- Nesting: ch 6 in service; raise ch 8 -> no dispatch. Raise ch 2 -> dispatch ch 2, in_service = 0x0044. Then eoi -> in_service = 0x0040.
- Masking and global disable: mask_in = 0x0010, raise ch 4 -> no dispatch, pending[4] = 1. Clear mask with int_en_n = 1 -> still nothing. Set int_en_n = 0 -> dispatch ch 4.
- Level ch 1 (TRIG_EDGE[1] = 0) held high: dispatch, eoi with irq_in[1] still high -> redispatch. Drop irq_in[1] before eoi -> no redispatch.
- Reset while ARMED with pending = 0x0101 -> all outputs return to reset values next edge. irq_in[0] held high -> dispatch ch 0 occurs after reset release.
